// File: rtl/audio_pkg.sv
// Shared audio types used by the arbiter and the downstream volume/PDM stages.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {ARB_PRIO, ARB_RR} arb_mode_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate counter; tick_out is high in the last cycle of each period.
module sample_tick_gen #(
    parameter int TICK_PERIOD = 2083
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_out = (cnt_q == CW'(TICK_PERIOD - 1));
        cnt_d    = tick_out ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_source_arbiter.sv
// Grants the shared audio output path to one of NUM_SRC sample producers once per sample tick
// and presents the taken sample with a one-cycle trigger in the following cycle.
module audio_source_arbiter
    import audio_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TICK_PERIOD = 2083,
    parameter int UNDERRUN_W  = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          mode_in,
    input  logic                          hold_en_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    input  logic [NUM_SRC*SAMPLE_W-1:0]   src_sample_in,
    output logic [NUM_SRC-1:0]            src_ready_out,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          audio_trigger_out,
    output logic [$clog2(NUM_SRC)-1:0]    grant_out,
    output logic                          grant_valid_out,
    output logic [UNDERRUN_W-1:0]         underrun_cnt_out
);

    localparam int          GW = $clog2(NUM_SRC);
    localparam int unsigned N  = NUM_SRC;

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                state_q, state_d;
    logic                  tick;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         win;
    logic                  found, keep;
    sample_t               sample_q, sample_d;
    logic                  trig_q, trig_d;
    logic [UNDERRUN_W-1:0] urc_q, urc_d;
    logic [NUM_SRC-1:0]    ready;
    arb_mode_t             mode;
    int unsigned           start, idx;

    sample_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_out (tick)
    );

    // Wrapping find-first from the start index. When re-arbitrating, the old owner is
    // known to be invalid, so searching all sources equals searching "the others".
    always_comb begin
        mode  = arb_mode_t'(mode_in);
        keep  = (state_q == ST_OWNED) && src_valid_in[grant_q];
        found = keep;
        win   = grant_q;
        start = (mode == ARB_RR) ? 32'(ptr_q) : 32'd0;
        idx   = 0;
        if (!keep) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = start + i;
                if (idx >= N) idx = idx - N;
                if (!found && src_valid_in[idx]) begin
                    found = 1'b1;
                    win   = GW'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        sample_d = sample_q;
        trig_d   = 1'b0;
        urc_d    = urc_q;
        ready    = '0;
        if (tick) begin
            trig_d = 1'b1;
            if (found) begin
                ready[win] = 1'b1;
                sample_d   = src_sample_in[win*SAMPLE_W +: SAMPLE_W];
                grant_d    = win;
                state_d    = ST_OWNED;
                if (!keep) begin
                    ptr_d = (win == GW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
                end
            end else begin
                state_d  = ST_IDLE;
                sample_d = hold_en_in ? sample_q : '0;
                if (urc_q != '1) urc_d = urc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            sample_q <= '0;
            trig_q   <= 1'b0;
            urc_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            sample_q <= sample_d;
            trig_q   <= trig_d;
            urc_q    <= urc_d;
        end
    end

    assign src_ready_out     = ready;
    assign sample_out        = sample_q;
    assign audio_trigger_out = trig_q;
    assign grant_out         = grant_q;
    assign grant_valid_out   = (state_q == ST_OWNED);
    assign underrun_cnt_out  = urc_q;

endmodule
